// File: rtl/calc_pkg.sv
// Shared constants for the calculator keypad entry and arithmetic stages:
// key codes, opcodes, operand widths and the entry FSM state encoding.
package calc_pkg;

  localparam int unsigned OPERAND_W  = 17;
  localparam int unsigned MAG_W      = 16;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned COUNT_W    = 3;
  localparam int unsigned KEY_W      = 5;
  localparam int unsigned OPC_W      = 2;

  localparam logic [KEY_W-1:0] KEY_ADD  = 5'h10;
  localparam logic [KEY_W-1:0] KEY_MUL  = 5'h11;
  localparam logic [KEY_W-1:0] KEY_SUB  = 5'h12;
  localparam logic [KEY_W-1:0] KEY_EQ   = 5'h13;
  localparam logic [KEY_W-1:0] KEY_CLR  = 5'h14;
  localparam logic [KEY_W-1:0] KEY_SIGN = 5'h15;
  localparam logic [KEY_W-1:0] KEY_BACK = 5'h16;

  localparam logic [OPC_W-1:0] OPC_ADD = 2'b00;
  localparam logic [OPC_W-1:0] OPC_MUL = 2'b01;
  localparam logic [OPC_W-1:0] OPC_SUB = 2'b10;

  typedef enum logic [1:0] {
    ST_ENTRY_FIRST = 2'd0,
    ST_OP_PENDING  = 2'd1,
    ST_ENTRY_NEXT  = 2'd2,
    ST_RESULT      = 2'd3
  } state_e;

  // Maps an operator key to the opcode seen by the arithmetic stage.
  function automatic logic [OPC_W-1:0] key_to_opcode(input logic [KEY_W-1:0] key);
    case (key)
      KEY_MUL: key_to_opcode = OPC_MUL;
      KEY_SUB: key_to_opcode = OPC_SUB;
      default: key_to_opcode = OPC_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_entry_if.sv
// Keypad/arithmetic-facing bundle of the entry stage. The slave side is the
// entry stage itself; the master side is the keypad plus arithmetic feedback.
interface calc_entry_if;
  import calc_pkg::*;

  logic                 key_valid;
  logic [KEY_W-1:0]     key_code;
  logic [OPERAND_W-1:0] answer;
  logic [OPERAND_W-1:0] V1;
  logic [OPERAND_W-1:0] V2;
  logic [OPC_W-1:0]     opcode;
  logic                 newop;
  logic                 newhex;
  logic                 eq;
  logic                 show_answer;
  logic                 key_drop;

  modport master (
    output key_valid, key_code, answer,
    input  V1, V2, opcode, newop, newhex, eq, show_answer, key_drop
  );

  modport slave (
    input  key_valid, key_code, answer,
    output V1, V2, opcode, newop, newhex, eq, show_answer, key_drop
  );

endinterface

// File: rtl/calc_entry_reg.sv
// Operand entry register: sign-magnitude value built from hex digits, with
// backspace, sign toggle and a digit count that saturates at four.
module calc_entry_reg
  import calc_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic                 back_i,
  input  logic                 toggle_i,
  input  logic                 clear_i,
  input  logic [DIGIT_W-1:0]   digit_i,
  output logic [OPERAND_W-1:0] value_o,
  output logic                 full_o
);

  logic [MAG_W-1:0]   mag_q,   mag_d;
  logic               sign_q,  sign_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               full_q,  full_d;

  // Toggle is applied after clear so clear+toggle yields negative zero.
  always_comb begin
    mag_d   = mag_q;
    sign_d  = sign_q;
    count_d = count_q;
    if (clear_i) begin
      mag_d   = '0;
      sign_d  = 1'b0;
      count_d = '0;
    end else if (load_i) begin
      mag_d   = MAG_W'(digit_i);
      sign_d  = 1'b0;
      count_d = COUNT_W'(1);
    end else if (shift_i && (count_q < COUNT_W'(MAX_DIGITS))) begin
      mag_d   = {mag_q[MAG_W-DIGIT_W-1:0], digit_i};
      count_d = count_q + COUNT_W'(1);
    end else if (back_i) begin
      mag_d   = mag_q >> DIGIT_W;
      count_d = (count_q == '0) ? '0 : count_q - COUNT_W'(1);
    end
    if (toggle_i) begin
      sign_d = ~sign_d;
    end
    full_d = (count_d == COUNT_W'(MAX_DIGITS));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mag_q   <= '0;
      sign_q  <= 1'b0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign value_o = {sign_q, mag_q};
  assign full_o  = full_q;

endmodule

// File: rtl/calc_entry.sv
// Keypad entry and operand sequencing for the calculator: decodes key strobes,
// sequences operands/opcode into the arithmetic stage and chains its result.
module calc_entry
  import calc_pkg::*;
#(
  parameter int unsigned HOLDOFF = 2
) (
  input  logic        clock,
  input  logic        reset,
  calc_entry_if.slave bus
);

  localparam int unsigned HO_W = (HOLDOFF == 0) ? 1 : $clog2(HOLDOFF + 1);

  state_e               state_q, state_d;
  logic [HO_W-1:0]      hold_q, hold_d;
  logic [OPERAND_W-1:0] v2_q, v2_d;
  logic [OPC_W-1:0]     opcode_q, opcode_d;
  logic                 newop_q, newop_d;
  logic                 newhex_q, newhex_d;
  logic                 eq_q, eq_d;
  logic                 show_q, show_d;
  logic                 drop_q, drop_d;

  logic                 ent_load, ent_shift, ent_back, ent_toggle, ent_clear;
  logic [OPERAND_W-1:0] entry_val;
  logic                 entry_full;

  logic accept, is_digit, is_op, is_eq, is_clr, is_sign, is_back, in_entry;

  assign accept   = bus.key_valid && (hold_q == '0);
  assign is_digit = ~bus.key_code[KEY_W-1];
  assign is_op    = (bus.key_code == KEY_ADD) || (bus.key_code == KEY_MUL) ||
                    (bus.key_code == KEY_SUB);
  assign is_eq    = (bus.key_code == KEY_EQ);
  assign is_clr   = (bus.key_code == KEY_CLR);
  assign is_sign  = (bus.key_code == KEY_SIGN);
  assign is_back  = (bus.key_code == KEY_BACK);
  assign in_entry = (state_q == ST_ENTRY_FIRST) || (state_q == ST_ENTRY_NEXT);

  calc_entry_reg u_entry (
    .clock    (clock),
    .reset    (reset),
    .load_i   (ent_load),
    .shift_i  (ent_shift),
    .back_i   (ent_back),
    .toggle_i (ent_toggle),
    .clear_i  (ent_clear),
    .digit_i  (bus.key_code[DIGIT_W-1:0]),
    .value_o  (entry_val),
    .full_o   (entry_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_ENTRY_FIRST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (is_clr) begin
        state_d = ST_ENTRY_FIRST;
      end else if (is_digit) begin
        if (state_q == ST_OP_PENDING)  state_d = ST_ENTRY_NEXT;
        else if (state_q == ST_RESULT) state_d = ST_ENTRY_FIRST;
      end else if (is_op) begin
        state_d = ST_OP_PENDING;
      end else if (is_eq) begin
        if (state_q == ST_ENTRY_NEXT) state_d = ST_RESULT;
      end else if (is_sign) begin
        if (state_q == ST_OP_PENDING) state_d = ST_ENTRY_NEXT;
      end
    end
  end

  // Datapath controls and next values for the registered outputs.
  always_comb begin
    ent_load   = 1'b0;
    ent_shift  = 1'b0;
    ent_back   = 1'b0;
    ent_toggle = 1'b0;
    ent_clear  = 1'b0;
    v2_d       = v2_q;
    opcode_d   = opcode_q;
    newop_d    = 1'b0;
    newhex_d   = 1'b0;
    eq_d       = 1'b0;
    drop_d     = bus.key_valid && (hold_q != '0);
    show_d     = (state_d == ST_RESULT);
    if (accept) begin
      if (is_clr) begin
        ent_clear = 1'b1;
        v2_d      = '0;
        opcode_d  = OPC_ADD;
        newop_d   = 1'b1;
      end else if (is_digit) begin
        if (in_entry) begin
          ent_shift = ~entry_full;
          newhex_d  = ~entry_full;
        end else begin
          ent_load = 1'b1;
          newhex_d = 1'b1;
        end
      end else if (is_op) begin
        opcode_d = key_to_opcode(bus.key_code);
        newop_d  = 1'b1;
        if (state_q == ST_ENTRY_FIRST) begin
          v2_d      = entry_val;
          ent_clear = 1'b1;
        end else if (state_q != ST_OP_PENDING) begin
          v2_d      = bus.answer;
          ent_clear = 1'b1;
        end
      end else if (is_eq) begin
        if (state_q == ST_ENTRY_NEXT) begin
          eq_d = 1'b1;
        end else if (state_q == ST_RESULT) begin
          eq_d = 1'b1;
          v2_d = bus.answer;
        end
      end else if (is_sign) begin
        if (in_entry) begin
          ent_toggle = 1'b1;
          newhex_d   = 1'b1;
        end else if (state_q == ST_OP_PENDING) begin
          ent_clear  = 1'b1;
          ent_toggle = 1'b1;
          newhex_d   = 1'b1;
        end
      end else if (is_back) begin
        if (in_entry) begin
          ent_back = 1'b1;
          newhex_d = 1'b1;
        end
      end
    end
  end

  // Holdoff restarts on every accepted key and counts down to zero.
  always_comb begin
    hold_d = hold_q;
    if (accept)              hold_d = HO_W'(HOLDOFF);
    else if (hold_q != '0)   hold_d = hold_q - HO_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q   <= '0;
      v2_q     <= '0;
      opcode_q <= OPC_ADD;
      newop_q  <= 1'b0;
      newhex_q <= 1'b0;
      eq_q     <= 1'b0;
      show_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      v2_q     <= v2_d;
      opcode_q <= opcode_d;
      newop_q  <= newop_d;
      newhex_q <= newhex_d;
      eq_q     <= eq_d;
      show_q   <= show_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.V1          = entry_val;
  assign bus.V2          = v2_q;
  assign bus.opcode      = opcode_q;
  assign bus.newop       = newop_q;
  assign bus.newhex      = newhex_q;
  assign bus.eq          = eq_q;
  assign bus.show_answer = show_q;
  assign bus.key_drop    = drop_q;

endmodule

// File: tb/tb_calc_entry.sv
// Scoreboard bench for calc_entry: directed key sequences push expected output
// snapshots; a monitor compares one snapshot on every output pulse.
module tb_calc_entry;
  import calc_pkg::*;

  localparam logic [3:0] P_OP   = 4'b1000;
  localparam logic [3:0] P_HEX  = 4'b0100;
  localparam logic [3:0] P_EQ   = 4'b0010;
  localparam logic [3:0] P_DROP = 4'b0001;

  typedef struct {
    logic [40:0] snap;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  calc_entry_if bus ();

  calc_entry #(.HOLDOFF(2)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [40:0] snap_now();
    return {bus.V1, bus.V2, bus.opcode, bus.show_answer,
            bus.newop, bus.newhex, bus.eq, bus.key_drop};
  endfunction

  task automatic expect_ev(input logic [16:0] v1, input logic [16:0] v2,
                           input logic [1:0] opc, input logic show,
                           input logic [3:0] pulses, input string nm);
    exp_t e;
    e.snap = {v1, v2, opc, show, pulses};
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // Called on a negedge; key is sampled at the next posedge, then 2 idle cycles.
  task automatic press(input logic [4:0] c);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    @(negedge clk);
    bus.key_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_now(input logic [40:0] want, input string nm);
    logic [40:0] got;
    got = snap_now();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.newop || bus.newhex || bus.eq || bus.key_drop)) begin
      exp_t e;
      logic [40:0] got;
      got = snap_now();
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got %h want no pulse", got);
      end else begin
        e = sb_q.pop_front();
        if (got !== e.snap) begin
          n_bad++;
          $display("FAIL %s: got %h want %h", e.name, got, e.snap);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.key_valid = 1'b1;
    bus.key_code  = 5'h05;
    bus.answer    = '0;
    repeat (3) @(negedge clk);
    check_now(41'h0, "reset_state");

    // Key held across reset release is accepted only on the first edge after it.
    expect_ev(17'h00005, 17'h0, 2'b00, 1'b0, P_HEX, "first_key_after_reset");
    rst = 1'b0;
    @(negedge clk);
    bus.key_valid = 1'b0;
    repeat (2) @(negedge clk);
    expect_ev(17'h0, 17'h0, 2'b00, 1'b0, P_OP, "clear_after_reset");
    press(KEY_CLR);

    // Four digits fill the entry, the fifth is ignored, backspace shifts right.
    expect_ev(17'h00001, 17'h0, 2'b00, 1'b0, P_HEX, "digit_1");
    press(5'h01);
    expect_ev(17'h00012, 17'h0, 2'b00, 1'b0, P_HEX, "digit_2");
    press(5'h02);
    expect_ev(17'h00123, 17'h0, 2'b00, 1'b0, P_HEX, "digit_3");
    press(5'h03);
    expect_ev(17'h01234, 17'h0, 2'b00, 1'b0, P_HEX, "digit_4");
    press(5'h04);
    press(5'h05);
    expect_ev(17'h00123, 17'h0, 2'b00, 1'b0, P_HEX, "backspace_full");
    press(KEY_BACK);
    expect_ev(17'h0, 17'h0, 2'b00, 1'b0, P_OP, "clear_a");
    press(KEY_CLR);

    // 12 + 5 =
    expect_ev(17'h00001, 17'h0, 2'b00, 1'b0, P_HEX, "b_digit_1");
    press(5'h01);
    expect_ev(17'h00012, 17'h0, 2'b00, 1'b0, P_HEX, "b_digit_2");
    press(5'h02);
    expect_ev(17'h0, 17'h00012, 2'b00, 1'b0, P_OP, "b_add");
    press(KEY_ADD);
    expect_ev(17'h00005, 17'h00012, 2'b00, 1'b0, P_HEX, "b_digit_5");
    press(5'h05);
    expect_ev(17'h00005, 17'h00012, 2'b00, 1'b1, P_EQ, "b_equals");
    press(KEY_EQ);

    // 7 - 2 * (chain with answer 5), then 3 =, repeat = with answer 0xA.
    expect_ev(17'h00007, 17'h00012, 2'b00, 1'b0, P_HEX, "c_digit_7_from_result");
    press(5'h07);
    expect_ev(17'h0, 17'h00007, 2'b10, 1'b0, P_OP, "c_sub");
    press(KEY_SUB);
    expect_ev(17'h00002, 17'h00007, 2'b10, 1'b0, P_HEX, "c_digit_2");
    press(5'h02);
    bus.answer = 17'h00005;
    expect_ev(17'h0, 17'h00005, 2'b01, 1'b0, P_OP, "c_chain_mul");
    press(KEY_MUL);
    expect_ev(17'h00003, 17'h00005, 2'b01, 1'b0, P_HEX, "c_digit_3");
    press(5'h03);
    expect_ev(17'h00003, 17'h00005, 2'b01, 1'b1, P_EQ, "c_equals");
    press(KEY_EQ);
    bus.answer = 17'h0000A;
    expect_ev(17'h00003, 17'h0000A, 2'b01, 1'b1, P_EQ, "c_repeat_equals");
    press(KEY_EQ);
    bus.answer = 17'h0001F;
    expect_ev(17'h0, 17'h0001F, 2'b00, 1'b0, P_OP, "c_chain_from_result");
    press(KEY_ADD);

    // Back-to-back keys: the second one is dropped and changes nothing.
    expect_ev(17'h00008, 17'h0001F, 2'b00, 1'b0, P_HEX, "d_digit_8");
    expect_ev(17'h00008, 17'h0001F, 2'b00, 1'b0, P_DROP, "d_key_drop");
    bus.key_valid = 1'b1;
    bus.key_code  = 5'h08;
    @(negedge clk);
    bus.key_code  = 5'h09;
    @(negedge clk);
    bus.key_valid = 1'b0;
    repeat (2) @(negedge clk);
    expect_ev(17'h00089, 17'h0001F, 2'b00, 1'b0, P_HEX, "d_digit_9_after_drop");
    press(5'h09);

    // Sign handling, including negative zero and backspace at count 0.
    expect_ev(17'h0, 17'h0001F, 2'b10, 1'b0, P_OP, "e_chain_sub");
    press(KEY_SUB);
    expect_ev(17'h10000, 17'h0001F, 2'b10, 1'b0, P_HEX, "e_sign_in_op_pending");
    press(KEY_SIGN);
    expect_ev(17'h10006, 17'h0001F, 2'b10, 1'b0, P_HEX, "e_digit_6_negative");
    press(5'h06);
    expect_ev(17'h10000, 17'h0001F, 2'b10, 1'b0, P_HEX, "e_backspace");
    press(KEY_BACK);
    expect_ev(17'h10000, 17'h0001F, 2'b10, 1'b0, P_HEX, "e_backspace_floor");
    press(KEY_BACK);
    expect_ev(17'h00000, 17'h0001F, 2'b10, 1'b0, P_HEX, "e_sign_toggle_back");
    press(KEY_SIGN);
    expect_ev(17'h00004, 17'h0001F, 2'b10, 1'b0, P_HEX, "e_digit_4");
    press(5'h04);
    expect_ev(17'h0, 17'h0, 2'b00, 1'b0, P_OP, "e_clear_entry_next");
    press(KEY_CLR);

    // Equals in ENTRY_FIRST is silently ignored.
    press(KEY_EQ);
    expect_ev(17'h00001, 17'h0, 2'b00, 1'b0, P_HEX, "f_digit_1");
    press(5'h01);

    // Async reset inside the holdoff window cancels it.
    expect_ev(17'h00012, 17'h0, 2'b00, 1'b0, P_HEX, "f_digit_2");
    bus.key_valid = 1'b1;
    bus.key_code  = 5'h02;
    @(negedge clk);
    bus.key_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_now(41'h0, "async_reset_mid_holdoff");
    expect_ev(17'h00003, 17'h0, 2'b00, 1'b0, P_HEX, "f_key_after_reset");
    rst = 1'b0;
    press(5'h03);

    repeat (4) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
